// File: rtl/seq_mdu_alu.sv
// seq_mdu_alu: registered EX-stage ALU with an iterative multiply/divide unit.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT(U), NOR, MFHI, MFLO) return their
// result one cycle after acceptance. MULT and DIV go through a one-bit-per-cycle
// engine and take DATA_W cycles. On completion they write the architectural
// HI/LO pair.
//
// Optional feature macro: SEQ_MDU_SIGNED_EN
//   Defined: adds MULTS (13) and DIVS (14), and makes opcode 7 a signed SLT.
//   Undefined: 13/14 are unknown codes, and 7 is an unsigned compare.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   op_valid      operation request
//   op_ready      block can accept an operation this cycle
//   control_input 4-bit operation code
//   input_1       operand A / dividend / multiplicand
//   input_2       operand B / divisor / multiplier
//   flush         synchronous abort of an in-flight MULT/DIV; blocks accept in IDLE
//   result        registered result, held between result_valid pulses
//   result_valid  one-cycle pulse, result and zero_flag valid
//   zero_flag     high when the held result is zero
//   busy          high while the multiply/divide engine is running
//   div_by_zero   one-cycle pulse on a divide with a zero divisor
module seq_mdu_alu #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        control_input,
  input  logic [DATA_W-1:0] input_1,
  input  logic [DATA_W-1:0] input_2,
  input  logic              flush,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              zero_flag,
  output logic              busy,
  output logic              div_by_zero
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_MFHI = 4'd11;
  localparam logic [3:0] OP_MFLO = 4'd12;
`ifdef SEQ_MDU_SIGNED_EN
  localparam logic [3:0] OP_MULTS = 4'd13;
  localparam logic [3:0] OP_DIVS  = 4'd14;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Engine registers: opnd holds the multiplicand or divisor. acc holds the
  // partial-product high half or the running remainder. shreg holds the
  // multiplier (shifting out, product low half shifting in) or the dividend
  // (shifting out, quotient shifting in).
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] shreg;
  logic              neg_q;    // negate product / quotient on the final edge
  logic              neg_r;    // negate remainder on the final edge
  logic              started;  // holds op_ready low until the first edge after reset

  logic              accept;
  logic              is_mul;
  logic              is_div;
  logic              is_signed_op;
  logic              div_zero;
  logic              neg_1;
  logic              neg_2;
  logic [DATA_W-1:0] mag_1;
  logic [DATA_W-1:0] mag_2;
  logic [DATA_W-1:0] alu_res;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   mul_acc_nx;
  logic [DATA_W-1:0]   mul_sh_nx;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [DATA_W-1:0]   div_acc_nx;
  logic [DATA_W-1:0]   div_sh_nx;
  logic [2*DATA_W-1:0] prod_mag;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Two's-complement negate when n is set.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
    cond_neg = n ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign op_ready = started && (state == IDLE) && !flush;
  assign busy     = (state == MUL_RUN) || (state == DIV_RUN);

  // Opcode decode, acceptance and operand magnitudes for the signed variants.
  always_comb begin
    is_mul       = (control_input == OP_MULT);
    is_div       = (control_input == OP_DIV);
    is_signed_op = 1'b0;
`ifdef SEQ_MDU_SIGNED_EN
    if (control_input == OP_MULTS) begin
      is_mul       = 1'b1;
      is_signed_op = 1'b1;
    end else if (control_input == OP_DIVS) begin
      is_div       = 1'b1;
      is_signed_op = 1'b1;
    end else begin
      is_signed_op = 1'b0;
    end
`endif
    div_zero = is_div && (input_2 == {DATA_W{1'b0}});
    accept   = op_valid && op_ready;
    neg_1    = is_signed_op && input_1[DATA_W-1];
    neg_2    = is_signed_op && input_2[DATA_W-1];
    mag_1    = cond_neg(input_1, neg_1);
    mag_2    = cond_neg(input_2, neg_2);
  end

  // Single-cycle result mux; unknown codes yield zero.
  always_comb begin
    alu_res = {DATA_W{1'b0}};
    case (control_input)
      OP_AND:  alu_res = input_1 & input_2;
      OP_OR:   alu_res = input_1 | input_2;
      OP_ADD:  alu_res = input_1 + input_2;
      OP_SUB:  alu_res = input_1 - input_2;
      OP_SLT: begin
`ifdef SEQ_MDU_SIGNED_EN
        alu_res = {{(DATA_W-1){1'b0}}, ($signed(input_1) < $signed(input_2))};
`else
        alu_res = {{(DATA_W-1){1'b0}}, (input_1 < input_2)};
`endif
      end
      OP_NOR:  alu_res = ~(input_1 | input_2);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = {DATA_W{1'b0}};
    endcase
  end

  // One shift-add and one restoring-divide step, plus the final sign fix-up.
  always_comb begin
    mul_sum    = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    mul_acc_nx = mul_sum[DATA_W:1];
    mul_sh_nx  = {mul_sum[0], shreg[DATA_W-1:1]};
    // The remainder stays below the divisor, so the shifted value fits in
    // DATA_W+1 bits. The top bit of the difference is then a clean borrow.
    div_shift  = {acc, shreg[DATA_W-1]};
    div_diff   = div_shift - {1'b0, opnd};
    if (!div_diff[DATA_W]) begin
      div_acc_nx = div_diff[DATA_W-1:0];
      div_sh_nx  = {shreg[DATA_W-2:0], 1'b1};
    end else begin
      div_acc_nx = div_shift[DATA_W-1:0];
      div_sh_nx  = {shreg[DATA_W-2:0], 1'b0};
    end
    prod_mag = {mul_acc_nx, mul_sh_nx};
    prod_fix = neg_q ? (~prod_mag + {{(2*DATA_W-1){1'b0}}, 1'b1}) : prod_mag;
    quot_fix = cond_neg(div_sh_nx, neg_q);
    rem_fix  = cond_neg(div_acc_nx, neg_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && (is_mul || is_div) && !div_zero) begin
          next_state = is_mul ? MUL_RUN : DIV_RUN;
        end else begin
          next_state = IDLE;
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (flush || (cnt == CNT_W'(1))) begin
          next_state = IDLE;
        end else begin
          next_state = state;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: result/flag registers, HI/LO, and the iteration engine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started      <= 1'b0;
      cnt          <= {CNT_W{1'b0}};
      hi           <= {DATA_W{1'b0}};
      lo           <= {DATA_W{1'b0}};
      opnd         <= {DATA_W{1'b0}};
      acc          <= {DATA_W{1'b0}};
      shreg        <= {DATA_W{1'b0}};
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      result       <= {DATA_W{1'b0}};
      zero_flag    <= 1'b0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      started      <= 1'b1;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (is_mul || is_div)) begin
            if (div_zero) begin
              // Divide by zero: report the current LO and leave HI/LO untouched.
              result       <= lo;
              zero_flag    <= (lo == {DATA_W{1'b0}});
              result_valid <= 1'b1;
              div_by_zero  <= 1'b1;
            end else begin
              acc   <= {DATA_W{1'b0}};
              cnt   <= CNT_W'(DATA_W);
              neg_q <= neg_1 ^ neg_2;
              neg_r <= neg_1;
              if (is_mul) begin
                opnd  <= mag_1;
                shreg <= mag_2;
              end else begin
                opnd  <= mag_2;
                shreg <= mag_1;
              end
            end
          end else if (accept) begin
            result       <= alu_res;
            zero_flag    <= (alu_res == {DATA_W{1'b0}});
            result_valid <= 1'b1;
          end
        end
        MUL_RUN: begin
          if (flush) begin
            cnt <= {CNT_W{1'b0}};
          end else begin
            acc   <= mul_acc_nx;
            shreg <= mul_sh_nx;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              hi           <= prod_fix[2*DATA_W-1:DATA_W];
              lo           <= prod_fix[DATA_W-1:0];
              result       <= prod_fix[DATA_W-1:0];
              zero_flag    <= (prod_fix[DATA_W-1:0] == {DATA_W{1'b0}});
              result_valid <= 1'b1;
            end
          end
        end
        DIV_RUN: begin
          if (flush) begin
            cnt <= {CNT_W{1'b0}};
          end else begin
            acc   <= div_acc_nx;
            shreg <= div_sh_nx;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              hi           <= rem_fix;
              lo           <= quot_fix;
              result       <= quot_fix;
              zero_flag    <= (quot_fix == {DATA_W{1'b0}});
              result_valid <= 1'b1;
            end
          end
        end
        default: cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mdu_alu.sv
// Directed self-checking bench for seq_mdu_alu (DATA_W=32).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_seq_mdu_alu;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   control_input;
  logic [W-1:0] input_1;
  logic [W-1:0] input_2;
  logic         flush;
  logic [W-1:0] result;
  logic         result_valid;
  logic         zero_flag;
  logic         busy;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_mdu_alu #(.DATA_W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .control_input(control_input),
    .input_1      (input_1),
    .input_2      (input_2),
    .flush        (flush),
    .result       (result),
    .result_valid (result_valid),
    .zero_flag    (zero_flag),
    .busy         (busy),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for one cycle. This returns on the falling edge after the accept edge.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    control_input = op;
    input_1       = a;
    input_2       = b;
    op_valid      = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Count falling edges until result_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; op_valid = 1'b0; flush = 1'b0;
    control_input = 4'd0; input_1 = 32'd0; input_2 = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero_flag); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%b exp=0", op_ready); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", op_ready); end
  endtask

  task automatic test_alu_ops;
    logic [3:0]   ops [13];
    logic [W-1:0] av  [13];
    logic [W-1:0] bv  [13];
    logic [W-1:0] ev  [13];
    ops = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd10, 4'd2, 4'd6, 4'd7, 4'd7, 4'd3, 4'd15, 4'd5, 4'd4};
    av  = '{32'd5, 32'd9, 32'hF0F0_1234, 32'hF000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0,
            32'd5, 32'hFFFF_FFFF, 32'h55, 32'h77, 32'h12, 32'h34};
    bv  = '{32'd7, 32'd9, 32'h0FF0_FF00, 32'h0000_000F, 32'd0, 32'd1, 32'd1,
            32'd3, 32'd1, 32'h66, 32'h88, 32'h21, 32'h43};
`ifdef SEQ_MDU_SIGNED_EN
    ev  = '{32'd12, 32'd0, 32'h00F0_1200, 32'hF000_000F, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
            32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
`else
    ev  = '{32'd12, 32'd0, 32'h00F0_1200, 32'hF000_000F, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
    for (int i = 0; i < 13; i++) begin
      do_op(ops[i], av[i], bv[i]);
      checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL alu_valid[%0d] got=%b exp=1", i, result_valid); end
      checks++; if (result !== ev[i]) begin failures++; $display("FAIL alu_result[%0d] got=%h exp=%h", i, result, ev[i]); end
      checks++; if (zero_flag !== (ev[i] == 32'd0)) begin failures++; $display("FAIL alu_zero[%0d] got=%b exp=%b", i, zero_flag, (ev[i] == 32'd0)); end
    end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL alu_valid_pulse got=%b exp=0", result_valid); end
    checks++; if (result !== 32'd0 || zero_flag !== 1'b1) begin failures++; $display("FAIL alu_hold got=%h/%b exp=0/1", result, zero_flag); end
`ifndef SEQ_MDU_SIGNED_EN
    do_op(4'd13, 32'd3, 32'd4);
    checks++; if (result !== 32'd0 || zero_flag !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL unsigned_op13 got=%h/%b/%b exp=0/1/0", result, zero_flag, busy); end
`endif
  endtask

  task automatic test_mult;
    int n;
    do_op(4'd8, 32'hFFFF_FFFF, 32'd2);
    checks++; if (busy !== 1'b1 || op_ready !== 1'b0) begin failures++; $display("FAIL mult_busy got=%b/%b exp=1/0", busy, op_ready); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL mult_early_valid got=%b exp=0", result_valid); end
    wait_valid(n);
    checks++; if (n !== 32) begin failures++; $display("FAIL mult_latency got=%0d exp=32", n); end
    checks++; if (result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_result got=%h exp=fffffffe", result); end
    checks++; if (busy !== 1'b0 || op_ready !== 1'b1) begin failures++; $display("FAIL mult_done_idle got=%b/%b exp=0/1", busy, op_ready); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL mult_valid_pulse got=%b exp=0", result_valid); end
    do_op(4'd11, 32'd0, 32'd0);
    checks++; if (result !== 32'd1) begin failures++; $display("FAIL mult_mfhi got=%h exp=1", result); end
    do_op(4'd12, 32'd0, 32'd0);
    checks++; if (result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_mflo got=%h exp=fffffffe", result); end
  endtask

  task automatic test_div;
    int n;
    do_op(4'd9, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL div_busy got=%b exp=1", busy); end
    wait_valid(n);
    checks++; if (n !== 32) begin failures++; $display("FAIL div_latency got=%0d exp=32", n); end
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL div_quot got=%h exp=e", result); end
    do_op(4'd11, 32'd0, 32'd0);
    checks++; if (result !== 32'd2) begin failures++; $display("FAIL div_rem got=%h exp=2", result); end
    // Divide by zero: an immediate pulse with LO reported and HI/LO unchanged.
    do_op(4'd9, 32'd5, 32'd0);
    checks++; if (div_by_zero !== 1'b1 || result_valid !== 1'b1) begin failures++; $display("FAIL dbz_pulse got=%b/%b exp=1/1", div_by_zero, result_valid); end
    checks++; if (result !== 32'd14 || busy !== 1'b0) begin failures++; $display("FAIL dbz_result got=%h/%b exp=e/0", result, busy); end
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL dbz_pulse_end got=%b/%b exp=0/0", div_by_zero, result_valid); end
    do_op(4'd11, 32'd0, 32'd0);
    checks++; if (result !== 32'd2) begin failures++; $display("FAIL dbz_hi_kept got=%h exp=2", result); end
  endtask

  task automatic test_flush;
    bit seen;
    seen = 1'b0;
    do_op(4'd8, 32'd3, 32'd4);
    repeat (9) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    flush = 1'b1;
    #1;
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", op_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || seen) begin failures++; $display("FAIL flush_abort busy=%b valid=%b seen=%b exp=0/0/0", busy, result_valid, seen); end
    flush = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_back got=%b exp=1", op_ready); end
    do_op(4'd12, 32'd0, 32'd0);
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL flush_lo_kept got=%h exp=e", result); end
    do_op(4'd11, 32'd0, 32'd0);
    checks++; if (result !== 32'd2) begin failures++; $display("FAIL flush_hi_kept got=%h exp=2", result); end
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    flush = 1'b1; control_input = 4'd2; input_1 = 32'd1; input_2 = 32'd1; op_valid = 1'b1;
    #1;
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_ready got=%b exp=0", op_ready); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0 || result !== 32'd2) begin failures++; $display("FAIL flush_idle_drop got=%b/%h exp=0/2", result_valid, result); end
    flush = 1'b0; op_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    control_input = 4'd8; input_1 = 32'd3; input_2 = 32'd4; op_valid = 1'b1;
    @(negedge clk);
    control_input = 4'd2; input_1 = 32'd1; input_2 = 32'd1;
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_run got=%b exp=0", op_ready); end
    wait_valid(n);
    checks++; if (n !== 32 || result !== 32'd12) begin failures++; $display("FAIL b2b_mult got=%0d/%h exp=32/c", n, result); end
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", op_ready); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b1 || result !== 32'd2) begin failures++; $display("FAIL b2b_add got=%b/%h exp=1/2", result_valid, result); end
    control_input = 4'd2; input_1 = 32'd1; input_2 = 32'd2;
    @(negedge clk);
    checks++; if (result_valid !== 1'b1 || result !== 32'd3) begin failures++; $display("FAIL b2b_seq0 got=%b/%h exp=1/3", result_valid, result); end
    control_input = 4'd6; input_1 = 32'd10; input_2 = 32'd4;
    @(negedge clk);
    checks++; if (result_valid !== 1'b1 || result !== 32'd6) begin failures++; $display("FAIL b2b_seq1 got=%b/%h exp=1/6", result_valid, result); end
    control_input = 4'd12;
    @(negedge clk);
    checks++; if (result_valid !== 1'b1 || result !== 32'd12) begin failures++; $display("FAIL b2b_mflo got=%b/%h exp=1/c", result_valid, result); end
    control_input = 4'd11;
    @(negedge clk);
    checks++; if (result !== 32'd0 || zero_flag !== 1'b1) begin failures++; $display("FAIL b2b_mfhi got=%h/%b exp=0/1", result, zero_flag); end
    op_valid = 1'b0;
  endtask

`ifdef SEQ_MDU_SIGNED_EN
  task automatic test_signed;
    int n;
    do_op(4'd14, 32'hFFFF_FFF9, 32'd2);
    wait_valid(n);
    checks++; if (n !== 32 || result !== 32'hFFFF_FFFD) begin failures++; $display("FAIL divs_quot got=%0d/%h exp=32/fffffffd", n, result); end
    do_op(4'd11, 32'd0, 32'd0);
    checks++; if (result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divs_rem got=%h exp=ffffffff", result); end
    do_op(4'd13, 32'hFFFF_FFFD, 32'd4);
    wait_valid(n);
    checks++; if (n !== 32 || result !== 32'hFFFF_FFF4) begin failures++; $display("FAIL mults_lo got=%0d/%h exp=32/fffffff4", n, result); end
    do_op(4'd11, 32'd0, 32'd0);
    checks++; if (result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mults_hi got=%h exp=ffffffff", result); end
  endtask
`endif

  task automatic test_reset_mid_run;
    do_op(4'd9, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || op_ready !== 1'b0) begin failures++; $display("FAIL rst_run_state got=%b/%b exp=0/0", busy, op_ready); end
    checks++; if (result !== 32'd0 || zero_flag !== 1'b0) begin failures++; $display("FAIL rst_run_result got=%h/%b exp=0/0", result, zero_flag); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_run_ready got=%b/%b exp=1/0", op_ready, busy); end
    do_op(4'd12, 32'd0, 32'd0);
    checks++; if (result !== 32'd0 || result_valid !== 1'b1) begin failures++; $display("FAIL rst_run_lo got=%h/%b exp=0/1", result, result_valid); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mult();
    test_div();
    test_flush();
    test_flush_idle();
    test_back_to_back();
`ifdef SEQ_MDU_SIGNED_EN
    test_signed();
`endif
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mdu_alu.md
Name: seq_mdu_alu

Overview:
- Parametrised, registered successor of the combinational EX-stage ALU.
- Keeps the same 4-bit operation encoding, adds an explicit valid/ready handshake, and holds architectural HI/LO registers.
- MULT and DIV run iteratively, one bit per cycle; the hazard unit stalls the pipeline on op_ready=0.
- Sits in the EX stage between the ID/EX and EX/MEM pipeline registers.

Parameters:
- DATA_W, 32: operand, result, HI and LO width; must be at least 4.
- CNT_W, $clog2(DATA_W)+1: iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- op_valid  input  1  operation request.
- op_ready  output  1  block can accept an operation this cycle.
- control_input  input  4  operation code.
- input_1  input  DATA_W  operand A / dividend / multiplicand.
- input_2  input  DATA_W  operand B / divisor / multiplier.
- flush  input  1  synchronous abort of any in-flight MULT/DIV.
- result  output  DATA_W  registered result.
- result_valid  output  1  one-cycle pulse; result and zero_flag are valid.
- zero_flag  output  1  high when result==0; registered together with result.
- busy  output  1  high in MUL_RUN or DIV_RUN.
- div_by_zero  output  1  one-cycle pulse on a DIV with input_2==0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - result=0, zero_flag=0, result_valid=0, div_by_zero=0, busy=0.
  - HI=0, LO=0, state=IDLE, counter=0.
  - op_ready=0 while reset_n is low; op_ready=1 from the first cycle after release.
- Accept: an operation is accepted on a rising edge where op_valid && op_ready. op_ready = (state==IDLE) && !flush.
- Opcodes and results:
  - 0 AND, 1 OR, 2 ADD (mod 2^DATA_W), 6 SUB (mod 2^DATA_W).
  - 7 SLTU: unsigned compare, result 1 or 0.
  - 10 NOR, 11 MFHI (result=HI), 12 MFLO (result=LO).
  - Any other code: result=0, zero_flag=1.
- Single-cycle ops (all except 8 and 9): result and result_valid are registered on the accept edge, so latency is 1. State stays IDLE, back-to-back every cycle.
- MFHI/MFLO read the HI/LO value as it stands on the accept edge.
- States: IDLE, MUL_RUN, DIV_RUN.
- MULT (8), unsigned shift-add:
  - Accept edge: latch operands, clear the accumulator, counter=DATA_W, IDLE->MUL_RUN.
  - Each edge in MUL_RUN: one iteration, counter decrements.
  - Edge where counter==1: {HI,LO} = full 2*DATA_W product, result=LO, result_valid pulses, ->IDLE.
  - Total: result_valid is high in the cycle after edge accept+DATA_W.
- DIV (9), unsigned restoring:
  - Same timing as MULT, via DIV_RUN.
  - Final edge: LO=quotient, HI=remainder, result=LO.
- DIV with input_2==0: no iteration. On the accept edge, div_by_zero=1, result_valid=1, result=LO (unchanged), and HI/LO stay unchanged. State stays IDLE.
- flush:
  - In MUL_RUN/DIV_RUN: the next edge goes ->IDLE, HI/LO unchanged, no result_valid.
  - In IDLE: flush blocks acceptance that cycle and the operation is dropped.
- busy=1 and op_ready=0 throughout MUL_RUN/DIV_RUN; op_valid is ignored there.
- op_ready returns to 1 in the cycle after the final iteration edge.
- result holds its last value between result_valid pulses.
- zero_flag always reflects the held result.
- Reset mid-iteration: everything returns to reset values immediately, and any partial product or quotient is discarded.

Optional Feature:
- Macro: SEQ_MDU_SIGNED_EN.
- Defined: adds opcodes 13 MULTS and 14 DIVS, and makes 7 a signed SLT.
  - MULTS/DIVS use the same iteration engine and the same DATA_W-cycle latency.
  - Operands are converted to magnitudes on accept, and signs are fixed on the final edge.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - DIVS by zero behaves like DIV by zero.
- Not defined: 13 and 14 fall into the "other code" case (result=0, zero_flag=1), and 7 stays unsigned.

Test Plan (DATA_W=32):
- Reset release, then ADD 5+7 at accept edge k -> result_valid at k+1, result=12, zero_flag=0. Then SUB 9-9 -> result=0, zero_flag=1.
- MULT 0xFFFFFFFF*2 accepted at edge k -> busy for 32 cycles, result_valid after edge k+32, HI=1, LO=0xFFFFFFFE. MFHI then returns 1 and MFLO returns 0xFFFFFFFE.
- DIV 100/7 -> LO=14, HI=2, result_valid 32 cycles after accept. DIV 5/0 -> div_by_zero and result_valid pulse next cycle, HI/LO unchanged.
- MULT 3*4 with flush asserted 10 cycles after accept -> no result_valid, IDLE next cycle, MFLO returns the prior LO.
- Drive op_valid continuously during MUL_RUN with ADD 1+1 -> not accepted until op_ready=1; then accepted with result 2.
- SEQ_MDU_SIGNED_EN defined: DIVS -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). SLT -1<1 -> 1.
